// File: rtl/demux4_reg_if.sv
// Bus bundle for demux4_reg: source-side sel/in handshake plus four lane outputs.
// Counter signals exist only when DEMUX_COUNT_EN is defined.
interface demux4_reg_if #(
  parameter int unsigned W = 32
);
  logic [1:0]   sel;
  logic [W-1:0] in;
  logic         in_valid;
  logic         in_ready;

  logic [W-1:0] one;
  logic [W-1:0] two;
  logic [W-1:0] three;
  logic [W-1:0] four;

  logic         one_valid;
  logic         two_valid;
  logic         three_valid;
  logic         four_valid;

  logic         one_ready;
  logic         two_ready;
  logic         three_ready;
  logic         four_ready;

`ifdef DEMUX_COUNT_EN
  logic [15:0]  cnt_one;
  logic [15:0]  cnt_two;
  logic [15:0]  cnt_three;
  logic [15:0]  cnt_four;
`endif

  modport slave (
    input  sel, in, in_valid,
    input  one_ready, two_ready, three_ready, four_ready,
    output in_ready,
    output one, two, three, four,
    output one_valid, two_valid, three_valid, four_valid
`ifdef DEMUX_COUNT_EN
    , output cnt_one, cnt_two, cnt_three, cnt_four
`endif
  );

  modport master (
    output sel, in, in_valid,
    output one_ready, two_ready, three_ready, four_ready,
    input  in_ready,
    input  one, two, three, four,
    input  one_valid, two_valid, three_valid, four_valid
`ifdef DEMUX_COUNT_EN
    , input cnt_one, cnt_two, cnt_three, cnt_four
`endif
  );
endinterface

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with a single-entry slot per lane and valid/ready flow control.
// Optional per-lane 16-bit acceptance counters are built when DEMUX_COUNT_EN is defined.
module demux4_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  demux4_reg_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  slot_t        state_q [4];
  slot_t        state_d [4];
  logic [W-1:0] data_q  [4];
  logic [3:0]   ready;
  logic [3:0]   load;
  logic [3:0]   drain;
  logic         accept;

  assign ready = {bus.four_ready, bus.three_ready, bus.two_ready, bus.one_ready};

  // A full slot can still accept when its sink drains it on the same edge.
  assign bus.in_ready = (state_q[bus.sel] == EMPTY) || ready[bus.sel];
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    load  = '0;
    drain = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      load[i]    = accept && (bus.sel == 2'(i));
      drain[i]   = (state_q[i] == FULL) && ready[i];
      if (load[i]) begin
        state_d[i] = FULL;
      end else if (drain[i]) begin
        state_d[i] = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Lane data only moves on a load; drained lanes keep showing their last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (load[i]) begin
          data_q[i] <= bus.in;
        end
      end
    end
  end

  assign bus.one         = data_q[0];
  assign bus.two         = data_q[1];
  assign bus.three       = data_q[2];
  assign bus.four        = data_q[3];
  assign bus.one_valid   = (state_q[0] == FULL);
  assign bus.two_valid   = (state_q[1] == FULL);
  assign bus.three_valid = (state_q[2] == FULL);
  assign bus.four_valid  = (state_q[3] == FULL);

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt_q [4];

  // Counters wrap silently at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (load[i]) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign bus.cnt_one   = cnt_q[0];
  assign bus.cnt_two   = cnt_q[1];
  assign bus.cnt_three = cnt_q[2];
  assign bus.cnt_four  = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// Self-checking bench for demux4_reg: directed scenarios plus random traffic against a per-lane queue model.
// Counter checks are compiled in when DEMUX_COUNT_EN is defined.
module tb_demux4_reg;
  localparam int unsigned W = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rdy;

  always #5 clk = ~clk;

  demux4_reg_if #(.W(W)) bus ();

  demux4_reg #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.one_ready   = rdy[0];
  assign bus.two_ready   = rdy[1];
  assign bus.three_ready = rdy[2];
  assign bus.four_ready  = rdy[3];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference: each lane is a FIFO of undelivered words; the sink pops, the source pushes.
  logic [W-1:0] lane_q  [4][$];
  logic [W-1:0] last_in [4];
  logic [15:0]  cnt_m   [4];

  function automatic logic [W-1:0] dut_data(int i);
    case (i)
      0: return bus.one;
      1: return bus.two;
      2: return bus.three;
      default: return bus.four;
    endcase
  endfunction

  function automatic logic dut_valid(int i);
    case (i)
      0: return bus.one_valid;
      1: return bus.two_valid;
      2: return bus.three_valid;
      default: return bus.four_valid;
    endcase
  endfunction

`ifdef DEMUX_COUNT_EN
  function automatic logic [15:0] dut_cnt(int i);
    case (i)
      0: return bus.cnt_one;
      1: return bus.cnt_two;
      2: return bus.cnt_three;
      default: return bus.cnt_four;
    endcase
  endfunction
`endif

  function automatic logic exp_ready();
    return (lane_q[bus.sel].size() == 0) || rdy[bus.sel];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      lane_q[i].delete();
      last_in[i] = '0;
      cnt_m[i]   = '0;
    end
  endtask

  task automatic model_edge();
    int  s;
    logic acc;
    s   = int'(bus.sel);
    acc = bus.in_valid && exp_ready();
    for (int i = 0; i < 4; i++) begin
      if (rdy[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
    end
    if (acc) begin
      lane_q[s].push_back(bus.in);
      last_in[s] = bus.in;
      cnt_m[s]   = cnt_m[s] + 16'd1;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("data%0d", i), dut_data(i), last_in[i]);
      check($sformatf("valid%0d", i), W'(dut_valid(i)), W'(lane_q[i].size() != 0));
`ifdef DEMUX_COUNT_EN
      check($sformatf("cnt%0d", i), W'(dut_cnt(i)), W'(cnt_m[i]));
`endif
    end
  endtask

  // Inputs are already applied; check in_ready, clock once, then check all lanes.
  task automatic step();
    #1;
    check("in_ready", W'(bus.in_ready), W'(exp_ready()));
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] words [4];
    words[0] = 32'hAAAA_AAAA;
    words[1] = 32'hBBBB_BBBB;
    words[2] = 32'hCCCC_CCCC;
    words[3] = 32'hDDDD_DDDD;

    rst_n        = 1'b0;
    rdy          = 4'h0;
    bus.in_valid = 1'b0;
    bus.sel      = 2'd0;
    bus.in       = '0;
    model_reset();
    #2;
    check("rst_in_ready", W'(bus.in_ready), W'(1'b1));
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Routing to every lane with all sinks ready
    rdy          = 4'hF;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.sel = 2'(k);
      bus.in  = words[k];
      step();
      check("route_data", dut_data(k), words[k]);
      check("route_valid", W'(dut_valid(k)), W'(1'b1));
    end
    bus.in_valid = 1'b0;
    step();

    // Backpressure on lane two
    rdy          = 4'b1101;
    bus.in_valid = 1'b1;
    bus.sel      = 2'd1;
    bus.in       = 32'h1111_1111;
    step();
    bus.in = 32'h2222_2222;
    step();
    check("bp_hold", bus.two, 32'h1111_1111);
    step();
    rdy = 4'hF;
    step();
    check("bp_second", bus.two, 32'h2222_2222);
    bus.in_valid = 1'b0;
    step();

    // Same-lane drain and load on lane three
    rdy          = 4'b1011;
    bus.in_valid = 1'b1;
    bus.sel      = 2'd2;
    bus.in       = 32'h3333_3333;
    step();
    rdy    = 4'hF;
    bus.in = 32'h4444_4444;
    step();
    check("dl_data", bus.three, 32'h4444_4444);
    check("dl_valid", W'(bus.three_valid), W'(1'b1));
    bus.in_valid = 1'b0;
    step();

    // Lane four stalled while lane one streams
    rdy          = 4'b0111;
    bus.in_valid = 1'b1;
    bus.sel      = 2'd3;
    bus.in       = 32'hDEAD_BEEF;
    step();
    bus.sel = 2'd0;
    for (int k = 0; k < 8; k++) begin
      bus.in = 32'h0100_0000 + W'(k);
      step();
    end
    check("iso_four", bus.four, 32'hDEAD_BEEF);
    check("iso_four_valid", W'(bus.four_valid), W'(1'b1));
    bus.in_valid = 1'b0;
    rdy          = 4'hF;
    step();

    // Random traffic
    repeat (300) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.sel      = 2'($urandom_range(0, 3));
      bus.in       = W'($urandom);
      rdy          = 4'($urandom_range(0, 15));
      step();
    end

    // Reset between edges with every lane full
    rdy          = 4'h0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.sel = 2'(k);
      bus.in  = W'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", W'(bus.in_ready), W'(1'b1));
    step();

`ifdef DEMUX_COUNT_EN
    // Counter wrap on lane one
    rdy          = 4'hF;
    bus.in_valid = 1'b1;
    bus.sel      = 2'd0;
    repeat (65535) begin
      bus.in = W'($urandom);
      @(posedge clk);
      model_edge();
      #1;
    end
    check("cnt_preload", W'(bus.cnt_one), W'(16'hFFFF));
    bus.in = W'($urandom);
    step();
    check("cnt_wrap", W'(bus.cnt_one), W'(16'h0000));
    bus.in_valid = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
